regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//   Parametrised multi-port register file for the MIPS datapath: NUM_RD registered read
//   ports and NUM_WR write ports, with optional write-to-read bypass and a hardwired zero
//   register. After reset, a clear sequencer zeroes the array one entry per cycle.
//   Per-cycle error flags report range, collision and busy conditions to the hazard logic.
// PARAMETERS
//   DW        32  data width
//   DEPTH     32  number of registers (need not be a power of 2)
//   AW        $clog2(DEPTH)  address width (derived; not overridable)
//   NUM_RD    2   read ports (1..4)
//   NUM_WR    2   write ports (1 or 2)
//   BYPASS    1   1 = same-cycle write data forwarded to a matching read
//   ZERO_REG  1   1 = register 0 reads 0; writes to it are dropped
// PORTS
//   clk      in   1            clock
//   reset    in   1            synchronous, active-high
//   rd_en    in   NUM_RD       per-port read enable; low = rd_data for that port holds
//   rd_addr  in   NUM_RD*AW    flattened read addresses; port p = [p*AW +: AW]
//   rd_data  out  NUM_RD*DW    flattened registered read data
//   wr_en    in   NUM_WR       per-port write enable
//   wr_addr  in   NUM_WR*AW    flattened write addresses
//   wr_data  in   NUM_WR*DW    flattened write data
//   ready    out  1            array cleared, accepting accesses
//   err      out  3            one-cycle pulses: [0] read out of range, [1] write collision, [2] access while !ready
// BEHAVIOUR
//   Reset: reset is synchronous, active-high; clock is clk. Reset enters CLEAR, sets clr_idx=0,
//     ready=0, rd_data=0 and err=0. Asserting reset mid-CLEAR or mid-operation restarts CLEAR
//     at index 0. The array contents are not reset directly.
//   FSM CLEAR: each cycle writes 0 to mem[clr_idx] and increments clr_idx. When clr_idx==DEPTH-1,
//     the next state is READY. ready rises on the DEPTH-th edge after reset deasserts.
//   CLEAR: wr_en is ignored and rd_data holds 0. Any rd_en or wr_en bit that is set raises err[2] next cycle.
//   READY: stays in READY until reset.
//   Read (READY, rd_en[p]=1): latency 1. rd_data[p] <= mem[addr] at the edge.
//     addr==0 && ZERO_REG: returns 0.
//     addr>=DEPTH: returns 0 and err[0]=1.
//     BYPASS=1 and an enabled write to the same legal address in the same cycle: returns that
//       write's data (the winning port's data on a collision).
//     BYPASS=0: returns the old contents.
//   Write (READY): mem[wr_addr] <= wr_data at the edge.
//     Dropped if addr>=DEPTH (err[0]) or if addr==0 && ZERO_REG.
//     Both ports enabled to the same address: port 1 wins and err[1]=1.
//   err: registered, recomputed every cycle and never sticky. Multiple bits may be set together.
//   Outputs are driven only from flops. There are no combinational paths from inputs to rd_data.
// STRUCTURE
//   Package regfile_pkg holds:
//     state enum {RF_CLEAR, RF_READY};
//     ERR_RANGE=0, ERR_COLL=1, ERR_BUSY=2;
//     helper function for flattened-bus slicing.
//   Sub-module regfile_clear_seq (counter + FSM): takes clk, reset and DEPTH; drives
//     clr_we, clr_idx and ready. The top level holds the array, the read/bypass muxes
//     and the error logic, and uses generate loops over NUM_RD and NUM_WR.
// TESTING (defaults unless stated)
//   1. Reset, then idle -> ready=0 for 32 cycles and 1 on the 32nd edge; all rd_data=0;
//      every address reads 0.
//   2. During CLEAR: wr_en[0]=1, addr 5, 0xDEAD_BEEF -> err[2] pulses. After ready, reading
//      addr 5 -> 0.
//   3. Write addr 3 = 0x1234_5678 and read port 0 addr 3 in the same cycle. BYPASS=1 ->
//      0x1234_5678 next cycle. BYPASS=0 -> 0, then 0x1234_5678 on the following read.
//   4. Both writes to addr 7 (port 0 0xAAAA_AAAA, port 1 0x5555_5555) -> err[1]=1 for one
//      cycle; addr 7 then reads 0x5555_5555.
//   5. Write 0xFFFF_FFFF to addr 0 -> addr 0 reads 0. DEPTH=24: read addr 30 -> 0 with err[0];
//      write addr 30 -> err[0], no array change.
//   6. Reset asserted mid-CLEAR at clr_idx=10 and after ready with data loaded -> ready drops
//      next edge and returns after a full DEPTH cycles; all entries read 0.

Source files
------------

// File: rtl/regfile_multiport_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Sequencer state: clearing the array, or open for normal access.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Bit positions in the err vector.
  localparam int ERR_RANGE = 0;
  localparam int ERR_COLL  = 1;
  localparam int ERR_BUSY  = 2;
  localparam int ERR_W     = 3;

  // Low bit of field 'port' in a flattened bus of 'width'-bit fields.
  function automatic int unsigned fld_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over every entry, then opens the array.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          ready
);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] idx_nxt;

  // State, index and the registered ready flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      ready   <= (state_nxt == RF_READY);
    end
  end

  // Next-state: one entry cleared per cycle; the last entry hands over to READY.
  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    clr_we    = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_we  = 1'b1;
        idx_nxt = clr_idx + 1'b1;
        if (clr_idx == AW'(DEPTH - 1)) begin
          state_nxt = RF_READY;
          idx_nxt   = '0;
        end
      end
      RF_READY: state_nxt = RF_READY;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: registered reads, optional write bypass, zero register,
// post-reset clear and per-cycle error pulses for the hazard logic.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int DW       = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic                 ready,
  output logic [ERR_W-1:0]     err
);

  // AW+1 bits so DEPTH itself is representable when it is a power of two.
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_idx;

  logic [NUM_RD-1:0][AW-1:0] ra;
  logic [NUM_WR-1:0][AW-1:0] wa;
  logic [NUM_WR-1:0][DW-1:0] wd;

  logic [NUM_RD-1:0] rd_oor;   // enabled read beyond the array
  logic [NUM_WR-1:0] wr_oor;   // enabled write beyond the array
  logic [NUM_WR-1:0] wr_ok;    // enabled write that actually lands in the array
  logic              wr_coll;
  logic [ERR_W-1:0]  err_nxt;

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clr (
    .clk     (clk),
    .reset   (reset),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  // Write-port decode: legality and the filtered enables used by array and bypass.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wa[w]     = wr_addr[fld_lo(w, AW) +: AW];
    assign wd[w]     = wr_data[fld_lo(w, DW) +: DW];
    assign wr_oor[w] = wr_en[w] && ({1'b0, wa[w]} >= DEPTH_V);
    assign wr_ok[w]  = wr_en[w] && !wr_oor[w] && !((ZERO_REG != 0) && (wa[w] == '0));
  end

  if (NUM_WR > 1) begin : g_coll
    assign wr_coll = wr_en[0] && wr_en[1] && (wa[0] == wa[1]);
  end else begin : g_nocoll
    assign wr_coll = 1'b0;
  end

  // Array update: clear walk until ready, then the write ports in ascending order
  // so the higher port wins a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready) begin
        if (clr_we) mem[clr_idx] <= '0;
      end else begin
        for (int w = 0; w < NUM_WR; w++)
          if (wr_ok[w]) mem[wa[w]] <= wd[w];
      end
    end
  end

  // Read ports: each has its own mux and output register.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DW-1:0] nxt;
    logic [DW-1:0] q;
    logic          zero_hit;

    assign ra[p]     = rd_addr[fld_lo(p, AW) +: AW];
    assign rd_oor[p] = rd_en[p] && ({1'b0, ra[p]} >= DEPTH_V);
    assign zero_hit  = (ZERO_REG != 0) && (ra[p] == '0);

    // Read mux: out-of-range and zero register give 0; a same-cycle write
    // to the address is forwarded when bypass is on (last matching port wins).
    always_comb begin
      nxt = '0;
      if (({1'b0, ra[p]} < DEPTH_V) && !zero_hit) begin
        nxt = mem[ra[p]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++)
            if (wr_ok[w] && (wa[w] == ra[p])) nxt = wd[w];
        end
      end
    end

    // Output register: forced to 0 while clearing, holds when the port is idle.
    always_ff @(posedge clk) begin
      if (reset || !ready) q <= '0;
      else if (rd_en[p])   q <= nxt;
    end

    assign rd_data[fld_lo(p, DW) +: DW] = q;
  end

  // Error flags for the coming cycle; range and collision only count once open.
  always_comb begin
    err_nxt            = '0;
    err_nxt[ERR_RANGE] = ready && ((|rd_oor) || (|wr_oor));
    err_nxt[ERR_COLL]  = ready && wr_coll;
    err_nxt[ERR_BUSY]  = !ready && ((|rd_en) || (|wr_en));
  end

  // Registered, non-sticky error pulses.
  always_ff @(posedge clk) begin
    if (reset) err <= '0;
    else       err <= err_nxt;
  end

endmodule
